// File: rtl/control_pipeline_if.sv
// Control-bundle port group for control_pipeline: ID-stage decoder inputs,
// stage-register outputs, hazard and forwarding selects.
interface control_pipeline_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
);
  logic               stall_in;
  logic               flush;
  logic               id_RegDst;
  logic               id_Branch;
  logic               id_MemRead;
  logic               id_MemtoReg;
  logic               id_MemWrite;
  logic               id_ALUSrc;
  logic               id_RegWrite;
  logic [ALUOP_W-1:0] id_ALUOp;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic [ALUOP_W-1:0] ex_ALUOp;
  logic               ex_ALUSrc;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic               mem_MemRead;
  logic               mem_MemWrite;
  logic               mem_Branch;
  logic               wb_MemtoReg;
  logic               wb_RegWrite;
  logic [REG_AW-1:0]  wb_write_reg;
  logic               hazard_stall;
  logic [1:0]         forward_a;
  logic [1:0]         forward_b;

  modport master (
    output stall_in, flush, id_RegDst, id_Branch, id_MemRead, id_MemtoReg,
           id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp, id_rs, id_rt, id_rd,
    input  ex_ALUOp, ex_ALUSrc, ex_rs, ex_rt, mem_MemRead, mem_MemWrite,
           mem_Branch, wb_MemtoReg, wb_RegWrite, wb_write_reg, hazard_stall,
           forward_a, forward_b
  );

  modport slave (
    input  stall_in, flush, id_RegDst, id_Branch, id_MemRead, id_MemtoReg,
           id_MemWrite, id_ALUSrc, id_RegWrite, id_ALUOp, id_rs, id_rt, id_rd,
    output ex_ALUOp, ex_ALUSrc, ex_rs, ex_rt, mem_MemRead, mem_MemWrite,
           mem_Branch, wb_MemtoReg, wb_RegWrite, wb_write_reg, hazard_stall,
           forward_a, forward_b
  );
endinterface

// File: rtl/control_pipeline.sv
// Carries the MIPS control bundle through ID/EX, EX/MEM and MEM/WB with RAW bubble
// insertion, stall and flush. CONTROL_PIPELINE_FORWARD_EN enables EX operand forwarding.
module control_pipeline #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  control_pipeline_if.slave  bus
);
  typedef struct packed {
    logic               RegDst;
    logic               Branch;
    logic               MemRead;
    logic               MemtoReg;
    logic               MemWrite;
    logic               ALUSrc;
    logic               RegWrite;
    logic [ALUOP_W-1:0] ALUOp;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
  } ex_t;

  typedef struct packed {
    logic              Branch;
    logic              MemRead;
    logic              MemtoReg;
    logic              MemWrite;
    logic              RegWrite;
    logic [REG_AW-1:0] write_reg;
  } mem_t;

  typedef struct packed {
    logic              MemtoReg;
    logic              RegWrite;
    logic [REG_AW-1:0] write_reg;
  } wb_t;

  ex_t               r_ex;
  mem_t              r_mem;
  wb_t               r_wb;
  ex_t               w_id_bundle;
  mem_t              w_ex_to_mem;
  wb_t               w_mem_to_wb;
  logic [REG_AW-1:0] w_ex_write_reg;
  logic              w_id_uses_rt;
  logic              w_match_ex;
  logic              w_hazard;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  always_comb begin
    w_id_bundle = '{RegDst: bus.id_RegDst, Branch: bus.id_Branch, MemRead: bus.id_MemRead,
                    MemtoReg: bus.id_MemtoReg, MemWrite: bus.id_MemWrite,
                    ALUSrc: bus.id_ALUSrc, RegWrite: bus.id_RegWrite, ALUOp: bus.id_ALUOp,
                    rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd};
    w_ex_write_reg = r_ex.RegDst ? r_ex.rd : r_ex.rt;
    w_ex_to_mem = '{Branch: r_ex.Branch, MemRead: r_ex.MemRead, MemtoReg: r_ex.MemtoReg,
                    MemWrite: r_ex.MemWrite, RegWrite: r_ex.RegWrite,
                    write_reg: w_ex_write_reg};
    w_mem_to_wb = '{MemtoReg: r_mem.MemtoReg, RegWrite: r_mem.RegWrite,
                    write_reg: r_mem.write_reg};
  end

  // rt is a true source for R-format, sw and beq; $0 never matches.
  assign w_id_uses_rt = !bus.id_ALUSrc | bus.id_MemWrite;
  assign w_match_ex   = r_ex.RegWrite && (w_ex_write_reg != '0) &&
                        ((w_ex_write_reg == bus.id_rs) ||
                         (w_id_uses_rt && (w_ex_write_reg == bus.id_rt)));

`ifdef CONTROL_PIPELINE_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic mem_rw, input logic [REG_AW-1:0] mem_wr,
                                         input logic wb_rw, input logic [REG_AW-1:0] wb_wr);
    if (mem_rw && (mem_wr != '0) && (mem_wr == src))
      return 2'b10;
    else if (wb_rw && (wb_wr != '0) && (wb_wr == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Only a load in EX cannot be forwarded in time.
  assign w_hazard = w_match_ex & r_ex.MemRead;
  assign w_fwd_a  = fwd_sel(r_ex.rs, r_mem.RegWrite, r_mem.write_reg, r_wb.RegWrite, r_wb.write_reg);
  assign w_fwd_b  = fwd_sel(r_ex.rt, r_mem.RegWrite, r_mem.write_reg, r_wb.RegWrite, r_wb.write_reg);
`else
  logic w_match_mem;

  // WB is covered by the write-first register file, so only EX and MEM stall.
  assign w_match_mem = r_mem.RegWrite && (r_mem.write_reg != '0) &&
                       ((r_mem.write_reg == bus.id_rs) ||
                        (w_id_uses_rt && (r_mem.write_reg == bus.id_rt)));
  assign w_hazard = w_match_ex | w_match_mem;
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!bus.stall_in) begin
      r_wb <= w_mem_to_wb;
      if (bus.flush) begin
        r_ex  <= '0;
        r_mem <= '0;
      end else if (w_hazard) begin
        r_ex  <= '0;
        r_mem <= w_ex_to_mem;
      end else begin
        r_ex  <= w_id_bundle;
        r_mem <= w_ex_to_mem;
      end
    end
  end

  assign bus.ex_ALUOp     = r_ex.ALUOp;
  assign bus.ex_ALUSrc    = r_ex.ALUSrc;
  assign bus.ex_rs        = r_ex.rs;
  assign bus.ex_rt        = r_ex.rt;
  assign bus.mem_MemRead  = r_mem.MemRead;
  assign bus.mem_MemWrite = r_mem.MemWrite;
  assign bus.mem_Branch   = r_mem.Branch;
  assign bus.wb_MemtoReg  = r_wb.MemtoReg;
  assign bus.wb_RegWrite  = r_wb.RegWrite;
  assign bus.wb_write_reg = r_wb.write_reg;
  assign bus.hazard_stall = w_hazard;
  assign bus.forward_a    = w_fwd_a;
  assign bus.forward_b    = w_fwd_b;
endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline; expectations follow CONTROL_PIPELINE_FORWARD_EN.
module tb_control_pipeline;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   fails   = 0;
  int   n;

`ifdef CONTROL_PIPELINE_FORWARD_EN
  localparam int         EXP_LW_STALL  = 1;
  localparam logic [1:0] EXP_FA_LW     = 2'b01;
  localparam int         EXP_ADD_STALL = 0;
  localparam logic [1:0] EXP_FWD_ADD   = 2'b10;
`else
  localparam int         EXP_LW_STALL  = 2;
  localparam logic [1:0] EXP_FA_LW     = 2'b00;
  localparam int         EXP_ADD_STALL = 2;
  localparam logic [1:0] EXP_FWD_ADD   = 2'b00;
`endif

  control_pipeline_if #(.REG_AW(5), .ALUOP_W(2)) bus ();

  control_pipeline #(.REG_AW(5), .ALUOP_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic regdst, input logic branch, input logic memread,
                          input logic memtoreg, input logic memwrite, input logic alusrc,
                          input logic regwrite, input logic [1:0] aluop,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.id_RegDst   = regdst;
    bus.id_Branch   = branch;
    bus.id_MemRead  = memread;
    bus.id_MemtoReg = memtoreg;
    bus.id_MemWrite = memwrite;
    bus.id_ALUSrc   = alusrc;
    bus.id_RegWrite = regwrite;
    bus.id_ALUOp    = aluop;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    #1;
  endtask

  task automatic id_nop();
    drive_id(0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask
  task automatic id_rfmt(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive_id(1, 0, 0, 0, 0, 0, 1, 2'b10, rs, rt, rd);
  endtask
  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    drive_id(0, 0, 1, 1, 0, 1, 1, 2'b00, rs, rt, 5'd0);
  endtask
  task automatic id_sw(input logic [4:0] rs, input logic [4:0] rt);
    drive_id(0, 0, 0, 0, 1, 1, 0, 2'b00, rs, rt, 5'd0);
  endtask
  task automatic id_beq(input logic [4:0] rs, input logic [4:0] rt);
    drive_id(0, 1, 0, 0, 0, 0, 0, 2'b01, rs, rt, 5'd0);
  endtask

  task automatic drain();
    id_nop();
    repeat (4) tick();
  endtask

  // Counts cycles with hazard_stall high while the ID bundle is held.
  task automatic count_stalls(output int cnt);
    cnt = 0;
    while (bus.hazard_stall === 1'b1 && cnt < 8) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.stall_in = 1'b0;
    bus.flush    = 1'b0;
    id_nop();
    repeat (2) tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_ex_ALUOp",     bus.ex_ALUOp, 0);
    check("rst_ex_ALUSrc",    bus.ex_ALUSrc, 0);
    check("rst_mem_MemRead",  bus.mem_MemRead, 0);
    check("rst_wb_RegWrite",  bus.wb_RegWrite, 0);
    check("rst_wb_write_reg", bus.wb_write_reg, 0);
    check("rst_hazard",       bus.hazard_stall, 0);
    check("rst_fwd_a",        bus.forward_a, 0);
    check("rst_fwd_b",        bus.forward_b, 0);

    // R-format latency: ex at +1, wb at +3
    id_rfmt(5'd1, 5'd2, 5'd8);
    tick();
    id_nop();
    check("lat_ex_ALUOp", bus.ex_ALUOp, 2'b10);
    tick();
    check("lat_wb_early", bus.wb_RegWrite, 0);
    tick();
    check("lat_wb_RegWrite",  bus.wb_RegWrite, 1);
    check("lat_wb_write_reg", bus.wb_write_reg, 8);
    drain();

    // lw $9 ; add $10,$9,$11
    id_lw(5'd0, 5'd9);
    check("lw_issue_hazard", bus.hazard_stall, 0);
    tick();
    id_rfmt(5'd9, 5'd11, 5'd10);
    check("lw_use_hazard", bus.hazard_stall, 1);
    count_stalls(n);
    check("lw_stall_cycles", 16'(n), 16'(EXP_LW_STALL));
    check("lw_bubble_ALUOp", bus.ex_ALUOp, 2'b00);
    tick();
    id_nop();
    check("lw_add_ex_ALUOp", bus.ex_ALUOp, 2'b10);
    check("lw_add_ex_rs",    bus.ex_rs, 9);
    check("lw_fwd_a",        bus.forward_a, EXP_FA_LW);
    check("lw_fwd_b",        bus.forward_b, 0);
    drain();

    // add $8,$1,$2 ; sub $12,$8,$8
    id_rfmt(5'd1, 5'd2, 5'd8);
    tick();
    id_rfmt(5'd8, 5'd8, 5'd12);
    count_stalls(n);
    check("add_stall_cycles", 16'(n), 16'(EXP_ADD_STALL));
    tick();
    id_nop();
    check("add_ex_rs",  bus.ex_rs, 8);
    check("add_fwd_a",  bus.forward_a, EXP_FWD_ADD);
    check("add_fwd_b",  bus.forward_b, EXP_FWD_ADD);
    drain();

    // Writer of $0 then a reader of $0
    id_rfmt(5'd1, 5'd2, 5'd0);
    tick();
    id_rfmt(5'd0, 5'd0, 5'd3);
    check("zero_hazard", bus.hazard_stall, 0);
    tick();
    id_nop();
    check("zero_fwd_a", bus.forward_a, 0);
    check("zero_fwd_b", bus.forward_b, 0);
    drain();

    // Flush with lw in EX and a load-use hazard pending
    id_rfmt(5'd1, 5'd2, 5'd5);
    tick();
    id_lw(5'd0, 5'd9);
    tick();
    id_rfmt(5'd9, 5'd3, 5'd4);
    check("flush_pre_hazard", bus.hazard_stall, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check("flush_ex_ALUOp",     bus.ex_ALUOp, 0);
    check("flush_ex_rs",        bus.ex_rs, 0);
    check("flush_mem_MemRead",  bus.mem_MemRead, 0);
    check("flush_mem_MemWrite", bus.mem_MemWrite, 0);
    check("flush_mem_Branch",   bus.mem_Branch, 0);
    check("flush_wb_RegWrite",  bus.wb_RegWrite, 1);
    check("flush_wb_write_reg", bus.wb_write_reg, 5);
    drain();

    // stall_in for 3 cycles mid-stream
    id_rfmt(5'd1, 5'd2, 5'd6);
    tick();
    id_sw(5'd3, 5'd4);
    tick();
    id_beq(5'd5, 5'd7);
    tick();
    id_rfmt(5'd1, 5'd2, 5'd13);
    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ex_ALUOp",     bus.ex_ALUOp, 2'b01);
      check("stall_mem_MemWrite", bus.mem_MemWrite, 1);
      check("stall_wb_write_reg", bus.wb_write_reg, 6);
    end
    bus.stall_in = 1'b0;
    tick();
    id_nop();
    check("rel_ex_ALUOp",     bus.ex_ALUOp, 2'b10);
    check("rel_mem_Branch",   bus.mem_Branch, 1);
    check("rel_wb_RegWrite",  bus.wb_RegWrite, 0);
    check("rel_wb_write_reg", bus.wb_write_reg, 4);
    tick();
    check("rel2_wb_write_reg", bus.wb_write_reg, 7);
    tick();
    check("rel3_wb_RegWrite",  bus.wb_RegWrite, 1);
    check("rel3_wb_write_reg", bus.wb_write_reg, 13);
    drain();

    // reset for one cycle mid-stream
    id_rfmt(5'd1, 5'd2, 5'd8);
    tick();
    id_lw(5'd0, 5'd9);
    tick();
    id_nop();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_ex_ALUOp",     bus.ex_ALUOp, 0);
    check("mrst_ex_ALUSrc",    bus.ex_ALUSrc, 0);
    check("mrst_mem_MemRead",  bus.mem_MemRead, 0);
    check("mrst_wb_RegWrite",  bus.wb_RegWrite, 0);
    check("mrst_wb_write_reg", bus.wb_write_reg, 0);
    check("mrst_hazard",       bus.hazard_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
